// File: rtl/cmd_fetch_decode_if.sv
// cmd_fetch_decode_if: request/clear controls, command buffer read port and decoded-field outputs
interface cmd_fetch_decode_if #(
  parameter int BUFFER_SIZE = 1024,
  parameter int INSTR_W = 8,
  parameter int ARG1_W = 3,
  parameter int ARG2_W = 5
);
  localparam int AW = $clog2(BUFFER_SIZE);
  localparam int CMD_W = INSTR_W + ARG1_W + ARG2_W;
  logic start_get_cmd;
  logic ptr_clr;
  logic [AW:0] cmd_count;
  logic [CMD_W-1:0] command_in;
  logic en_rd_cmd;
  logic [AW-1:0] rd_addr_cmd;
  logic busy;
  logic done_get_cmd;
  logic [INSTR_W-1:0] instr;
  logic [ARG1_W-1:0] arg1;
  logic [ARG2_W-1:0] arg2;
  logic [1:0] error;
  modport master (
    output start_get_cmd, ptr_clr, cmd_count, command_in,
    input en_rd_cmd, rd_addr_cmd, busy, done_get_cmd, instr, arg1, arg2, error
  );
  modport slave (
    input start_get_cmd, ptr_clr, cmd_count, command_in,
    output en_rd_cmd, rd_addr_cmd, busy, done_get_cmd, instr, arg1, arg2, error
  );
endinterface

// File: rtl/cmd_fetch_decode.sv
// cmd_fetch_decode: fetches one command word from the command buffer, decodes and validates it
module cmd_fetch_decode #(
  parameter int BUFFER_SIZE = 1024,
  parameter int INSTR_W = 8,
  parameter int ARG1_W = 3,
  parameter int ARG2_W = 5,
  parameter int RD_LATENCY = 1,
  parameter int MAX_STO_ARG2 = 10
) (
  input logic clk,
  input logic rst,
  cmd_fetch_decode_if.slave bus
);
  localparam int AW = $clog2(BUFFER_SIZE);
  localparam int CMD_W = INSTR_W + ARG1_W + ARG2_W;
  localparam logic [1:0] WAIT_LD = 2'(RD_LATENCY > 1 ? RD_LATENCY - 2 : 0);
  typedef enum logic [2:0] {IDLE, REQ, WAIT, DECODE, DONE} state_t;
  state_t state, state_nx;
  logic [1:0] cnt;
  logic [INSTR_W-1:0] op;
  logic [ARG1_W-1:0] a1;
  logic [ARG2_W-1:0] a2;
  logic empty;
  assign op = bus.command_in[CMD_W-1 -: INSTR_W];
  assign a1 = bus.command_in[ARG2_W +: ARG1_W];
  assign a2 = bus.command_in[ARG2_W-1:0];
  assign empty = bus.cmd_count == '0;
  assign bus.en_rd_cmd = state == REQ;
  assign bus.busy = state != IDLE;
  assign bus.done_get_cmd = state == DONE;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = !bus.start_get_cmd ? IDLE : empty ? DONE : REQ;
      REQ: state_nx = RD_LATENCY == 1 ? DECODE : WAIT;
      WAIT: state_nx = cnt == '0 ? DECODE : WAIT;
      DECODE: state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nx;
  // WAIT lasts RD_LATENCY-1 cycles: loaded on REQ, leaves WAIT when it reads zero
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else if (state == REQ) cnt <= WAIT_LD;
    else if (state == WAIT && cnt != '0) cnt <= cnt - 1'b1;
  always_ff @(posedge clk or negedge rst)
    if (!rst) bus.rd_addr_cmd <= '0;
    else if (bus.ptr_clr) bus.rd_addr_cmd <= '0;
    else if (state == REQ) bus.rd_addr_cmd <= bus.rd_addr_cmd == AW'(BUFFER_SIZE - 1) ? '0 : bus.rd_addr_cmd + 1'b1;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      bus.instr <= '0;
      bus.arg1 <= '0;
      bus.arg2 <= '0;
      bus.error <= '0;
    end else if (state == IDLE && bus.start_get_cmd && empty) bus.error <= 2'd3;
    else if (state == DECODE) begin
      if (op > INSTR_W'(3)) bus.error <= 2'd1;
      else if (op == '0 && a2 > ARG2_W'(MAX_STO_ARG2)) bus.error <= 2'd2;
      else begin
        bus.error <= 2'd0;
        bus.instr <= op;
        bus.arg1 <= op == INSTR_W'(3) ? '0 : a1;
        bus.arg2 <= (op == INSTR_W'(1) || op == INSTR_W'(3)) ? '0 : a2;
      end
    end
endmodule
